// File: rtl/bullet_pkg.sv
// Shared types and helpers for the bullet pool arbiter: facing, player id, fire-request states.
package bullet_pkg;

  typedef enum logic [1:0] {
    DirLeft  = 2'b00,
    DirRight = 2'b01,
    DirDown  = 2'b10,
    DirUp    = 2'b11
  } dir_t;

  typedef enum logic {
    PlayerP1 = 1'b0,
    PlayerP2 = 1'b1
  } player_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPend = 2'b01,
    StHold = 2'b10
  } fire_state_t;

  localparam int unsigned MaxSlots = 8;
  localparam int unsigned CountW   = 4;

  function automatic logic [CountW-1:0] count_ones(input logic [MaxSlots-1:0] v);
    logic [CountW-1:0] n;
    n = '0;
    for (int i = 0; i < MaxSlots; i++) begin
      n = n + {{(CountW - 1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/fire_request_fsm.sv
// Per-player fire edge/hold tracking and shot cooldown; raises o_req while a shot may be granted.
module fire_request_fsm
  import bullet_pkg::*;
#(
  parameter int unsigned COOLDOWN = 8
) (
  input  logic frame_clk,
  input  logic Reset,
  input  logic i_fire,
  input  logic i_below_cap,
  input  logic i_grant,
  output logic o_req,
  output logic o_cooling
);

  localparam int unsigned CdW = (COOLDOWN == 0) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CdW-1:0] CdLoad = CdW'(COOLDOWN);

  fire_state_t    r_state;
  fire_state_t    w_state_next;
  logic [CdW-1:0] r_cd;
  logic [CdW-1:0] w_cd_next;
  logic           w_wants;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state <= StIdle;
      r_cd    <= '0;
    end else begin
      r_state <= w_state_next;
      r_cd    <= w_cd_next;
    end
  end

  always_comb begin
    w_wants      = ((r_state == StIdle) && i_fire) || (r_state == StPend);
    o_req        = w_wants && (r_cd == '0) && i_below_cap;
    o_cooling    = (r_cd != '0);
    w_state_next = r_state;
    w_cd_next    = r_cd;

    unique case (r_state)
      StIdle: if (i_fire) w_state_next = i_grant ? StHold : StPend;
      // A pending shot survives until granted or the key is let go.
      StPend: begin
        if (i_grant) w_state_next = StHold;
        else if (!i_fire) w_state_next = StIdle;
      end
      StHold: if (!i_fire) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase

    if (i_grant) w_cd_next = CdLoad;
    else if (r_cd != '0) w_cd_next = r_cd - 1'b1;
  end

endmodule

// File: rtl/bullet_pool_arbiter.sv
// Shares NUM_SLOTS bullet slots between two players: launch pulses, slot ownership, in-flight caps.
module bullet_pool_arbiter
  import bullet_pkg::*;
#(
  parameter int unsigned NUM_SLOTS      = 4,
  parameter int unsigned MAX_PER_PLAYER = 2,
  parameter int unsigned COOLDOWN       = 8
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic                   i_p1_fire,
  input  logic                   i_p2_fire,
  input  logic [1:0]             i_p1_dir,
  input  logic [1:0]             i_p2_dir,
  input  logic [NUM_SLOTS-1:0]   i_slot_release,
  output logic [NUM_SLOTS-1:0]   o_slot_launch,
  output logic [NUM_SLOTS-1:0]   o_slot_busy,
  output logic [NUM_SLOTS-1:0]   o_slot_owner,
  output logic [2*NUM_SLOTS-1:0] o_slot_dir,
  output logic [3:0]             o_p1_inflight,
  output logic [3:0]             o_p2_inflight,
  output logic                   o_p1_cooling,
  output logic                   o_p2_cooling
);

  localparam logic [CountW-1:0] MaxLive = CountW'(MAX_PER_PLAYER);

  logic [NUM_SLOTS-1:0]   r_launch;
  logic [NUM_SLOTS-1:0]   r_busy;
  logic [NUM_SLOTS-1:0]   r_owner;
  logic [2*NUM_SLOTS-1:0] r_dir;
  logic [CountW-1:0]      r_p1_inflight;
  logic [CountW-1:0]      r_p2_inflight;
  player_t                r_prio;

  logic [NUM_SLOTS-1:0]   w_free;
  logic [NUM_SLOTS-1:0]   w_first_oh;
  logic [NUM_SLOTS-1:0]   w_second_oh;
  logic                   w_first_ok;
  logic                   w_second_ok;
  logic [CountW-1:0]      w_p1_live;
  logic [CountW-1:0]      w_p2_live;
  logic                   w_p1_below;
  logic                   w_p2_below;
  logic                   w_p1_req;
  logic                   w_p2_req;
  logic                   w_p1_grant;
  logic                   w_p2_grant;
  logic                   w_toggle;
  logic [NUM_SLOTS-1:0]   w_p1_slot;
  logic [NUM_SLOTS-1:0]   w_p2_slot;
  logic [NUM_SLOTS-1:0]   w_launch;
  logic [NUM_SLOTS-1:0]   w_busy_next;
  logic [NUM_SLOTS-1:0]   w_owner_next;
  logic [2*NUM_SLOTS-1:0] w_dir_next;
  logic [CountW-1:0]      w_p1_inflight_next;
  logic [CountW-1:0]      w_p2_inflight_next;
  player_t                w_prio_next;

  fire_request_fsm #(
    .COOLDOWN (COOLDOWN)
  ) u_p1_fsm (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .i_fire      (i_p1_fire),
    .i_below_cap (w_p1_below),
    .i_grant     (w_p1_grant),
    .o_req       (w_p1_req),
    .o_cooling   (o_p1_cooling)
  );

  fire_request_fsm #(
    .COOLDOWN (COOLDOWN)
  ) u_p2_fsm (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .i_fire      (i_p2_fire),
    .i_below_cap (w_p2_below),
    .i_grant     (w_p2_grant),
    .o_req       (w_p2_req),
    .o_cooling   (o_p2_cooling)
  );

  // A slot dying this frame is both free for relaunch and no longer counts against its owner.
  assign w_free     = ~r_busy | i_slot_release;
  assign w_p1_live  = count_ones(MaxSlots'(r_busy & ~r_owner & ~i_slot_release));
  assign w_p2_live  = count_ones(MaxSlots'(r_busy & r_owner & ~i_slot_release));
  assign w_p1_below = (w_p1_live < MaxLive);
  assign w_p2_below = (w_p2_live < MaxLive);

  always_comb begin
    w_first_oh  = '0;
    w_second_oh = '0;
    w_first_ok  = 1'b0;
    w_second_ok = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_free[i]) begin
        if (!w_first_ok) begin
          w_first_ok    = 1'b1;
          w_first_oh[i] = 1'b1;
        end else if (!w_second_ok) begin
          w_second_ok    = 1'b1;
          w_second_oh[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_p1_grant = 1'b0;
    w_p2_grant = 1'b0;
    w_p1_slot  = '0;
    w_p2_slot  = '0;
    w_toggle   = 1'b0;
    if (w_p1_req && w_p2_req) begin
      if (w_second_ok) begin
        w_p1_grant = 1'b1;
        w_p2_grant = 1'b1;
        w_p1_slot  = (r_prio == PlayerP1) ? w_first_oh : w_second_oh;
        w_p2_slot  = (r_prio == PlayerP1) ? w_second_oh : w_first_oh;
      end else if (w_first_ok) begin
        w_toggle = 1'b1;
        if (r_prio == PlayerP1) begin
          w_p1_grant = 1'b1;
          w_p1_slot  = w_first_oh;
        end else begin
          w_p2_grant = 1'b1;
          w_p2_slot  = w_first_oh;
        end
      end
    end else if (w_p1_req && w_first_ok) begin
      w_p1_grant = 1'b1;
      w_p1_slot  = w_first_oh;
    end else if (w_p2_req && w_first_ok) begin
      w_p2_grant = 1'b1;
      w_p2_slot  = w_first_oh;
    end
    w_prio_next = r_prio;
    if (w_toggle) w_prio_next = (r_prio == PlayerP1) ? PlayerP2 : PlayerP1;
  end

  // Launch beats release on the same slot: busy stays set and owner/dir take the new shot.
  always_comb begin
    w_launch     = w_p1_slot | w_p2_slot;
    w_busy_next  = (r_busy & ~i_slot_release) | w_launch;
    w_owner_next = r_owner;
    w_dir_next   = r_dir;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_p1_slot[i]) begin
        w_owner_next[i]        = PlayerP1;
        w_dir_next[2*i +: 2]   = i_p1_dir;
      end else if (w_p2_slot[i]) begin
        w_owner_next[i]        = PlayerP2;
        w_dir_next[2*i +: 2]   = i_p2_dir;
      end
    end
    w_p1_inflight_next = count_ones(MaxSlots'(w_busy_next & ~w_owner_next));
    w_p2_inflight_next = count_ones(MaxSlots'(w_busy_next & w_owner_next));
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_launch      <= '0;
      r_busy        <= '0;
      r_owner       <= '0;
      r_dir         <= '0;
      r_p1_inflight <= '0;
      r_p2_inflight <= '0;
      r_prio        <= PlayerP1;
    end else begin
      r_launch      <= w_launch;
      r_busy        <= w_busy_next;
      r_owner       <= w_owner_next;
      r_dir         <= w_dir_next;
      r_p1_inflight <= w_p1_inflight_next;
      r_p2_inflight <= w_p2_inflight_next;
      r_prio        <= w_prio_next;
    end
  end

  assign o_slot_launch = r_launch;
  assign o_slot_busy   = r_busy;
  assign o_slot_owner  = r_owner;
  assign o_slot_dir    = r_dir;
  assign o_p1_inflight = r_p1_inflight;
  assign o_p2_inflight = r_p2_inflight;

endmodule

// File: tb/tb_bullet_pool_arbiter.sv
// Bench for bullet_pool_arbiter: directed scenarios plus random play against a slot-list model.
module tb_bullet_pool_arbiter;

  localparam int NS = 4;
  localparam int MAXP = 2;
  localparam int CD = 8;

  logic frame_clk = 1'b0;
  logic Reset = 1'b1;
  always #5 frame_clk = ~frame_clk;

  logic          p1_fire = 0, p2_fire = 0;
  logic [1:0]    p1_dir = 0, p2_dir = 0;
  logic [NS-1:0] rel = 0;
  logic [NS-1:0] o_launch, o_busy, o_owner;
  logic [2*NS-1:0] o_dir;
  logic [3:0]    o_p1_inf, o_p2_inf;
  logic          o_p1_cool, o_p2_cool;

  // Second instance with a looser cap so a single free slot can be contested.
  logic          c_p1_fire = 0, c_p2_fire = 0;
  logic [NS-1:0] c_rel = 0;
  logic [NS-1:0] c_launch, c_busy, c_owner;
  logic [2*NS-1:0] c_dir;
  logic [3:0]    c_p1_inf, c_p2_inf;
  logic          c_p1_cool, c_p2_cool;

  int n_vec = 0;
  int n_err = 0;

  bullet_pool_arbiter #(.NUM_SLOTS(NS), .MAX_PER_PLAYER(MAXP), .COOLDOWN(CD)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .i_p1_fire(p1_fire), .i_p2_fire(p2_fire),
    .i_p1_dir(p1_dir), .i_p2_dir(p2_dir), .i_slot_release(rel), .o_slot_launch(o_launch),
    .o_slot_busy(o_busy), .o_slot_owner(o_owner), .o_slot_dir(o_dir),
    .o_p1_inflight(o_p1_inf), .o_p2_inflight(o_p2_inf), .o_p1_cooling(o_p1_cool),
    .o_p2_cooling(o_p2_cool));

  bullet_pool_arbiter #(.NUM_SLOTS(NS), .MAX_PER_PLAYER(3), .COOLDOWN(CD)) dut_c (
    .frame_clk(frame_clk), .Reset(Reset), .i_p1_fire(c_p1_fire), .i_p2_fire(c_p2_fire),
    .i_p1_dir(2'b00), .i_p2_dir(2'b11), .i_slot_release(c_rel), .o_slot_launch(c_launch),
    .o_slot_busy(c_busy), .o_slot_owner(c_owner), .o_slot_dir(c_dir),
    .o_p1_inflight(c_p1_inf), .o_p2_inflight(c_p2_inf), .o_p1_cooling(c_p1_cool),
    .o_p2_cooling(c_p2_cool));

  // Reference model: slot table plus per-player "waiting"/"needs key-up" flags and a frame timer.
  bit       m_busy[NS];
  bit       m_owner[NS];
  bit [1:0] m_dir[NS];
  bit       m_launch[NS];
  int       m_cd[2];
  bit       m_pend[2];
  bit       m_held[2];
  int       m_prio;

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_busy[i] = 0; m_owner[i] = 0; m_dir[i] = 0; m_launch[i] = 0;
    end
    for (int p = 0; p < 2; p++) begin
      m_cd[p] = 0; m_pend[p] = 0; m_held[p] = 0;
    end
    m_prio = 0;
  endfunction

  function automatic void model_step();
    int freel[$];
    int live[2];
    int slot_of[2];
    bit elig[2];
    bit gr[2];
    bit fire[2];
    bit [1:0] din[2];
    fire[0] = p1_fire; fire[1] = p2_fire;
    din[0] = p1_dir; din[1] = p2_dir;
    for (int i = 0; i < NS; i++) if (!m_busy[i] || rel[i]) freel.push_back(i);
    for (int p = 0; p < 2; p++) begin
      live[p] = 0;
      for (int i = 0; i < NS; i++)
        if (m_busy[i] && (int'(m_owner[i]) == p) && !rel[i]) live[p]++;
      elig[p] = (m_pend[p] || (!m_held[p] && fire[p])) && (m_cd[p] == 0) && (live[p] < MAXP);
      gr[p] = 0; slot_of[p] = -1;
    end
    if (elig[0] && elig[1]) begin
      if (freel.size() >= 2) begin
        gr[0] = 1; gr[1] = 1;
        slot_of[m_prio] = freel[0]; slot_of[1 - m_prio] = freel[1];
      end else if (freel.size() == 1) begin
        gr[m_prio] = 1; slot_of[m_prio] = freel[0];
        m_prio = 1 - m_prio;
      end
    end else begin
      for (int p = 0; p < 2; p++)
        if (elig[p] && freel.size() > 0) begin gr[p] = 1; slot_of[p] = freel[0]; end
    end
    for (int i = 0; i < NS; i++) begin
      m_launch[i] = 0;
      if (m_busy[i] && rel[i]) m_busy[i] = 0;
    end
    for (int p = 0; p < 2; p++) begin
      if (gr[p]) begin
        m_busy[slot_of[p]] = 1; m_owner[slot_of[p]] = p[0];
        m_dir[slot_of[p]] = din[p]; m_launch[slot_of[p]] = 1;
        m_held[p] = 1; m_pend[p] = 0; m_cd[p] = CD;
      end else begin
        if (m_cd[p] > 0) m_cd[p]--;
        if (m_pend[p] && !fire[p]) m_pend[p] = 0;
        else if (!m_pend[p] && !m_held[p] && fire[p]) m_pend[p] = 1;
        else if (m_held[p] && !fire[p]) m_held[p] = 0;
      end
    end
  endfunction

  function automatic logic [29:0] model_snap();
    logic [NS-1:0] l, b, o;
    logic [2*NS-1:0] d;
    logic [3:0] n1, n2;
    n1 = 0; n2 = 0; d = 0;
    for (int i = 0; i < NS; i++) begin
      l[i] = m_launch[i]; b[i] = m_busy[i]; o[i] = m_busy[i] & m_owner[i];
      if (m_busy[i]) begin
        d[2*i +: 2] = m_dir[i];
        if (m_owner[i]) n2++; else n1++;
      end
    end
    return {l, b, o, d, n1, n2, m_cd[0] != 0, m_cd[1] != 0};
  endfunction

  function automatic logic [29:0] dut_snap();
    logic [2*NS-1:0] d;
    for (int i = 0; i < NS; i++) d[2*i +: 2] = o_busy[i] ? o_dir[2*i +: 2] : 2'b00;
    return {o_launch, o_busy, o_owner & o_busy, d, o_p1_inf, o_p2_inf, o_p1_cool, o_p2_cool};
  endfunction

  task automatic tick();
    @(posedge frame_clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    p1_fire = 0; p2_fire = 0; rel = 0; c_p1_fire = 0; c_p2_fire = 0; c_rel = 0;
    Reset = 1;
    repeat (2) @(posedge frame_clk);
    #1;
    Reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    if (dut_snap() !== 30'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", dut_snap());
    end
    n_vec++;
    if ({c_launch, c_busy, c_p1_inf, c_p2_inf, c_p1_cool, c_p2_cool} !== 18'd0) begin
      n_err++; $display("FAIL reset_outputs_c: busy %b launch %b", c_busy, c_launch);
    end
    n_vec++;
  endtask

  task automatic test_first_shot();
    do_reset();
    p1_fire = 1; p1_dir = 2'b01;
    tick();
    p1_fire = 0;
    if (o_launch !== 4'b0001 || o_busy !== 4'b0001) begin
      n_err++; $display("FAIL first_launch: launch %b busy %b want 0001/0001", o_launch, o_busy);
    end
    n_vec++;
    if (o_dir[1:0] !== 2'b01 || o_p1_inf !== 4'd1 || o_p1_cool !== 1'b1) begin
      n_err++; $display("FAIL first_state: dir %b inf %0d cool %b want 01/1/1",
                        o_dir[1:0], o_p1_inf, o_p1_cool);
    end
    n_vec++;
    p1_dir = 2'b11;
    tick();
    if (o_launch !== 4'b0000 || o_dir[1:0] !== 2'b01) begin
      n_err++; $display("FAIL launch_one_cycle: launch %b dir %b want 0000/01", o_launch, o_dir[1:0]);
    end
    n_vec++;
  endtask

  task automatic test_hold_cooldown();
    int launches;
    int first_at;
    do_reset();
    launches = 0;
    p1_fire = 1;
    for (int f = 0; f < 20; f++) begin
      tick();
      if (o_launch != 0) launches++;
    end
    p1_fire = 0;
    if (launches !== 1) begin
      n_err++; $display("FAIL hold_no_repeat: got %0d launches want 1", launches);
    end
    n_vec++;
    do_reset();
    p1_fire = 1; tick();
    p1_fire = 0; tick(); tick();
    p1_fire = 1;
    first_at = -1;
    for (int k = 3; k < 20 && first_at < 0; k++) begin
      tick();
      if (dut_snap() !== model_snap()) begin
        n_err++; $display("FAIL cooldown_frame%0d: got %h want %h", k, dut_snap(), model_snap());
      end
      n_vec++;
      if (o_launch != 0) first_at = k;
    end
    // Counter holds COOLDOWN after the grant edge and must read 0 before the next grant edge.
    if (first_at !== CD + 1 || o_launch !== 4'b0010) begin
      n_err++; $display("FAIL cooldown_release: launch at frame %0d slot %b want %0d/0010",
                        first_at, o_launch, CD + 1);
    end
    n_vec++;
    p1_fire = 0; tick();
  endtask

  task automatic test_cap_release();
    do_reset();
    p1_fire = 1; tick(); p1_fire = 0;
    repeat (10) tick();
    p1_fire = 1; tick(); p1_fire = 0; tick();
    if (o_p1_inf !== 4'd2 || o_busy !== 4'b0011) begin
      n_err++; $display("FAIL cap_fill: inf %0d busy %b want 2/0011", o_p1_inf, o_busy);
    end
    n_vec++;
    repeat (10) tick();
    p1_fire = 1; tick();
    if (o_launch !== 4'b0000) begin
      n_err++; $display("FAIL cap_block: launch %b want 0000", o_launch);
    end
    n_vec++;
    p1_fire = 0; tick();
    p1_fire = 1; rel = 4'b0001; tick();
    if (o_launch !== 4'b0001 || o_p1_inf !== 4'd2 || o_busy !== 4'b0011) begin
      n_err++; $display("FAIL cap_release_relaunch: launch %b inf %0d busy %b want 0001/2/0011",
                        o_launch, o_p1_inf, o_busy);
    end
    n_vec++;
    p1_fire = 0; rel = 0; tick();
  endtask

  task automatic test_release_idle();
    rel = 4'b1000; tick(); rel = 0;
    if (o_busy !== 4'b0011 || o_launch !== 4'b0000 || dut_snap() !== model_snap()) begin
      n_err++; $display("FAIL idle_release: got %h want %h", dut_snap(), model_snap());
    end
    n_vec++;
    p2_fire = 1; p2_dir = 2'b10; rel = 4'b0001; tick();
    p2_fire = 0; rel = 0;
    if (o_launch !== 4'b0001 || o_busy !== 4'b0011 || o_owner[0] !== 1'b1 ||
        o_p1_inf !== 4'd1 || o_p2_inf !== 4'd1) begin
      n_err++; $display("FAIL same_slot_launch_release: launch %b busy %b owner %b inf %0d/%0d",
                        o_launch, o_busy, o_owner, o_p1_inf, o_p2_inf);
    end
    n_vec++;
    if (dut_snap() !== model_snap()) begin
      n_err++; $display("FAIL same_slot_model: got %h want %h", dut_snap(), model_snap());
    end
    n_vec++;
    tick();
  endtask

  task automatic test_contention();
    do_reset();
    c_p1_fire = 1; c_p2_fire = 1; tick();
    c_p1_fire = 0; c_p2_fire = 0;
    if (c_launch !== 4'b0011 || c_owner[1:0] !== 2'b10) begin
      n_err++; $display("FAIL dual_grant: launch %b owner %b want 0011/xx10", c_launch, c_owner);
    end
    n_vec++;
    repeat (10) tick();
    c_p1_fire = 1; tick(); c_p1_fire = 0;
    repeat (10) tick();
    c_p1_fire = 1; c_p2_fire = 1; tick();
    if (c_launch !== 4'b1000 || c_owner[3] !== 1'b0 || c_p1_inf !== 4'd3 || c_p2_inf !== 4'd1) begin
      n_err++; $display("FAIL last_slot_p1: launch %b owner %b inf %0d/%0d want 1000/P1/3/1",
                        c_launch, c_owner, c_p1_inf, c_p2_inf);
    end
    n_vec++;
    c_p1_fire = 0; c_rel = 4'b0010; tick(); c_rel = 0;
    if (c_launch !== 4'b0010 || c_busy !== 4'b1111 || c_owner[1] !== 1'b1 || c_p2_inf !== 4'd1) begin
      n_err++; $display("FAIL pend_retry_p2: launch %b busy %b owner %b inf %0d",
                        c_launch, c_busy, c_owner, c_p2_inf);
    end
    n_vec++;
    c_p2_fire = 0; c_rel = 4'b1000; tick(); c_rel = 0;
    repeat (10) tick();
    c_p1_fire = 1; c_p2_fire = 1; tick();
    if (c_launch !== 4'b1000 || c_owner[3] !== 1'b1) begin
      n_err++; $display("FAIL prio_toggled: launch %b owner %b want 1000 owned by P2", c_launch, c_owner);
    end
    n_vec++;
    c_rel = 4'b0001; tick(); c_rel = 0;
    if (c_launch !== 4'b0001 || c_owner[0] !== 1'b0) begin
      n_err++; $display("FAIL loser_retry_p1: launch %b owner %b want 0001 owned by P1", c_launch, c_owner);
    end
    n_vec++;
    c_p1_fire = 0; c_p2_fire = 0; tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    p1_fire = 1; tick(); p1_fire = 0;
    repeat (10) tick();
    p1_fire = 1; tick(); p1_fire = 0;
    p2_fire = 1; tick(); p2_fire = 0; tick();
    p2_fire = 1; tick();
    if (o_busy !== 4'b0111 || o_launch !== 4'b0000) begin
      n_err++; $display("FAIL midflight_setup: busy %b launch %b want 0111/0000", o_busy, o_launch);
    end
    n_vec++;
    #2 Reset = 1;
    p1_fire = 0; p2_fire = 0;
    #1;
    if (dut_snap() !== 30'd0) begin
      n_err++; $display("FAIL async_reset: got %h want 0", dut_snap());
    end
    n_vec++;
    @(posedge frame_clk); #1;
    Reset = 0;
    model_reset();
    for (int f = 0; f < 3; f++) begin
      tick();
      if (o_launch !== 4'b0000 || o_busy !== 4'b0000) begin
        n_err++; $display("FAIL post_reset_quiet%0d: launch %b busy %b want 0", f, o_launch, o_busy);
      end
      n_vec++;
    end
    p2_fire = 1; p2_dir = 2'b00; tick(); p2_fire = 0;
    if (o_launch !== 4'b0001 || o_owner[0] !== 1'b1 || o_p2_inf !== 4'd1) begin
      n_err++; $display("FAIL post_reset_press: launch %b owner %b inf %0d", o_launch, o_owner, o_p2_inf);
    end
    n_vec++;
  endtask

  task automatic test_random();
    do_reset();
    for (int f = 0; f < 400; f++) begin
      if ($urandom_range(0, 9) < 3) p1_fire = ~p1_fire;
      if ($urandom_range(0, 9) < 3) p2_fire = ~p2_fire;
      p1_dir = 2'($urandom_range(0, 3));
      p2_dir = 2'($urandom_range(0, 3));
      for (int i = 0; i < NS; i++)
        rel[i] = m_busy[i] ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
      tick();
      if (dut_snap() !== model_snap()) begin
        n_err++; $display("FAIL random_frame%0d: got %h want %h", f, dut_snap(), model_snap());
      end
      n_vec++;
    end
    p1_fire = 0; p2_fire = 0; rel = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_shot();
    test_hold_cooldown();
    test_cap_release();
    test_release_idle();
    test_contention();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
